// File: rtl/playbus_pkg.sv
// Shared types and default widths for the PlayBus level 1 command path.
// The controller imports the same package so both sides agree on widths and function codes.
package playbus_pkg;

  localparam int DEF_DATA_W          = 4;
  localparam int DEF_ADDR_W          = 3;
  localparam int DEF_FUNC_W          = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  typedef enum logic [2:0] {
    SW_TO_RAM    = 3'd0,
    SW_TO_BUS    = 3'd1,
    SW_TO_LED    = 3'd2,
    RAM_TO_BUS   = 3'd3,
    EPROM_TO_LED = 3'd4,
    EPROM_TO_RAM = 3'd5,
    RAM_TO_LED   = 3'd6,
    FUNC_SPARE   = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PENDING      = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/playbus_cmd_input_if.sv
// Command handshake between the input stage (master) and the controller (slave).
interface playbus_cmd_input_if import playbus_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FUNC_W = DEF_FUNC_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [FUNC_W-1:0] cmd_func;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              overrun;

  modport master (
    output cmd_valid, cmd_func, cmd_addr, cmd_data, overrun,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_func, cmd_addr, cmd_data, overrun,
    output cmd_ready
  );

endinterface

// File: rtl/playbus_debounce.sv
// Two-flop synchroniser and counter debouncer for the go push-button.
// press_o is a registered one-cycle pulse that lines up with db_btn_o rising.
module playbus_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic db_btn_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             meta_q;
  logic             sync_q;
  logic             db_q;
  logic             db_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             differ_s;
  logic             expire_s;

  assign differ_s = sync_q ^ db_q;
  assign expire_s = differ_s && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Counter runs only while the synchronised level disagrees with the debounced one.
  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    if (!differ_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (expire_s) begin
      cnt_d   = {CNT_W{1'b0}};
      db_d    = ~db_q;
      press_d = ~db_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, debounced level, counter and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign db_btn_o = db_q;
  assign press_o  = press_q;

endmodule

// File: rtl/playbus_cmd_input.sv
// PlayBus command front end: synchronises switches, debounces "go" and hands one
// command per clean press to the controller over a valid/ready handshake.
module playbus_cmd_input import playbus_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int FUNC_W          = DEF_FUNC_W
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [DATA_W-1:0]   sw0,
  input  logic [ADDR_W-1:0]   sw1,
  input  logic [FUNC_W-1:0]   sw2,
  input  logic                go_btn,
  playbus_cmd_input_if.master cmd
);

  localparam int SW_W = DATA_W + ADDR_W + FUNC_W;

  logic [SW_W-1:0]   sw_meta_q;
  logic [SW_W-1:0]   sw_sync_q;
  logic              db_btn_s;
  logic              press_s;
  cmd_state_t        state_q;
  cmd_state_t        state_d;
  logic [FUNC_W-1:0] func_q;
  logic [FUNC_W-1:0] func_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              valid_d;
  logic              overrun_q;
  logic              overrun_d;

  playbus_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (n_reset),
    .btn_i    (go_btn),
    .db_btn_o (db_btn_s),
    .press_o  (press_s)
  );

  // Switches are only synchronised; the operator keeps them steady around a press.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sw_meta_q <= {SW_W{1'b0}};
      sw_sync_q <= {SW_W{1'b0}};
    end else begin
      sw_meta_q <= {sw2, sw1, sw0};
      sw_sync_q <= sw_meta_q;
    end
  end

  // Next-state: acceptance beats a coincident press, which is only flagged as overrun.
  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_s) begin
          state_d = ST_PENDING;
          data_d  = sw_sync_q[DATA_W-1:0];
          addr_d  = sw_sync_q[DATA_W +: ADDR_W];
          func_d  = sw_sync_q[DATA_W+ADDR_W +: FUNC_W];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (cmd.cmd_ready) begin
          if (press_s) begin
            overrun_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (db_btn_s) begin
            state_d = ST_WAIT_RELEASE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (press_s) begin
          overrun_d = 1'b1;
        end else begin
          state_d = ST_PENDING;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!db_btn_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_PENDING);
  end

  // FSM state and registered command outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= ST_IDLE;
      func_q    <= {FUNC_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_func  = func_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_data  = data_q;
  assign cmd.overrun   = overrun_q;

endmodule
